// File: rtl/e203_icb_rr_arb2.sv
// Two-master to one-slave ICB arbiter.
// Commands are granted round-robin and pass straight through with zero cycles of latency.
// Each accepted command pushes its master ID into a small FIFO, and responses are routed
// back to their issuers in order by popping that FIFO.
module e203_icb_rr_arb2 #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned OUTS_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  // master 0
  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic            m0_icb_cmd_read,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,
  // master 1
  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic            m1_icb_cmd_read,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,
  // shared slave
  output logic            s_icb_cmd_valid,
  input  logic            s_icb_cmd_ready,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic            s_icb_cmd_read,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_rsp_valid,
  output logic            s_icb_rsp_ready,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata,
  // status
  output logic            arb_busy,
  output logic            rsp_orphan
);

  localparam int unsigned PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic                  rr_ptr_q,     rr_ptr_d;
  logic                  lock_vld_q,   lock_vld_d;
  logic                  lock_id_q,    lock_id_d;
  logic [OUTS_DEPTH-1:0] fifo_q,       fifo_d;
  logic [PW-1:0]         wptr_q,       wptr_d;
  logic [PW-1:0]         rptr_q,       rptr_d;
  logic [CW-1:0]         cnt_q,        cnt_d;
  logic                  rsp_orphan_q, rsp_orphan_d;

  logic grant;
  logic full;
  logic empty;
  logic head;
  logic cmd_hsk;
  logic rsp_hsk;

  assign full  = (cnt_q == CW'(OUTS_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  // Grant selection: a stalled command keeps its grant; otherwise use round-robin on conflict.
  always_comb begin
    grant = 1'b0;
    if (lock_vld_q)                             grant = lock_id_q;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid) grant = rr_ptr_q;
    else if (m1_icb_cmd_valid)                  grant = 1'b1;
  end

  // Command path: mux the granted master onto the slave and block it while the ID FIFO is full.
  always_comb begin
    s_icb_cmd_valid  = (grant ? m1_icb_cmd_valid : m0_icb_cmd_valid) & ~full;
    s_icb_cmd_addr   = grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    s_icb_cmd_read   = grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
    s_icb_cmd_wdata  = grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    s_icb_cmd_wmask  = grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    m0_icb_cmd_ready = ~grant & s_icb_cmd_ready & ~full;
    m1_icb_cmd_ready =  grant & s_icb_cmd_ready & ~full;
  end

  // Response path: steer the response to the master at the FIFO head; err/rdata are broadcast.
  always_comb begin
    m0_icb_rsp_valid = s_icb_rsp_valid & ~empty & ~head;
    m1_icb_rsp_valid = s_icb_rsp_valid & ~empty &  head;
    m0_icb_rsp_err   = s_icb_rsp_err;
    m1_icb_rsp_err   = s_icb_rsp_err;
    m0_icb_rsp_rdata = s_icb_rsp_rdata;
    m1_icb_rsp_rdata = s_icb_rsp_rdata;
    s_icb_rsp_ready  = ~empty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  end

  assign cmd_hsk    = s_icb_cmd_valid & s_icb_cmd_ready;
  assign rsp_hsk    = s_icb_rsp_valid & s_icb_rsp_ready;
  assign arb_busy   = ~empty;
  assign rsp_orphan = rsp_orphan_q;

  // Next state: round-robin pointer, grant lock, ID FIFO and the sticky orphan flag.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_id_d    = lock_id_q;
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    rsp_orphan_d = rsp_orphan_q;

    if (cmd_hsk) begin
      fifo_d[wptr_q] = grant;
      wptr_d         = wptr_q + PW'(1);
      rr_ptr_d       = ~grant;
      lock_vld_d     = 1'b0;
    end else if (s_icb_cmd_valid) begin
      lock_vld_d = 1'b1;
      lock_id_d  = grant;
    end

    if (rsp_hsk) rptr_d = rptr_q + PW'(1);

    case ({cmd_hsk, rsp_hsk})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (s_icb_rsp_valid && empty) rsp_orphan_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 1'b0;
      lock_vld_q   <= 1'b0;
      lock_id_q    <= 1'b0;
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      rsp_orphan_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_id_q    <= lock_id_d;
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      rsp_orphan_q <= rsp_orphan_d;
    end
  end

endmodule

// File: tb/tb_e203_icb_rr_arb2.sv
// Directed testbench for e203_icb_rr_arb2 (AW=DW=32, OUTS_DEPTH=2).
module tb_e203_icb_rr_arb2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready, m0_rsp_err;
  logic [AW-1:0] m0_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata, m0_rsp_rdata;
  logic [DW/8-1:0] m0_cmd_wmask;
  logic m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready, m1_rsp_err;
  logic [AW-1:0] m1_cmd_addr;
  logic [DW-1:0] m1_cmd_wdata, m1_rsp_rdata;
  logic [DW/8-1:0] m1_cmd_wmask;
  logic s_cmd_valid, s_cmd_ready, s_cmd_read, s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [AW-1:0] s_cmd_addr;
  logic [DW-1:0] s_cmd_wdata, s_rsp_rdata;
  logic [DW/8-1:0] s_cmd_wmask;
  logic arb_busy, rsp_orphan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_icb_rr_arb2 #(.AW(AW), .DW(DW), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_cmd_valid), .m0_icb_cmd_ready(m0_cmd_ready), .m0_icb_cmd_addr(m0_cmd_addr),
    .m0_icb_cmd_read(m0_cmd_read), .m0_icb_cmd_wdata(m0_cmd_wdata), .m0_icb_cmd_wmask(m0_cmd_wmask),
    .m0_icb_rsp_valid(m0_rsp_valid), .m0_icb_rsp_ready(m0_rsp_ready), .m0_icb_rsp_err(m0_rsp_err),
    .m0_icb_rsp_rdata(m0_rsp_rdata),
    .m1_icb_cmd_valid(m1_cmd_valid), .m1_icb_cmd_ready(m1_cmd_ready), .m1_icb_cmd_addr(m1_cmd_addr),
    .m1_icb_cmd_read(m1_cmd_read), .m1_icb_cmd_wdata(m1_cmd_wdata), .m1_icb_cmd_wmask(m1_cmd_wmask),
    .m1_icb_rsp_valid(m1_rsp_valid), .m1_icb_rsp_ready(m1_rsp_ready), .m1_icb_rsp_err(m1_rsp_err),
    .m1_icb_rsp_rdata(m1_rsp_rdata),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready), .s_icb_cmd_addr(s_cmd_addr),
    .s_icb_cmd_read(s_cmd_read), .s_icb_cmd_wdata(s_cmd_wdata), .s_icb_cmd_wmask(s_cmd_wmask),
    .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_ready(s_rsp_ready), .s_icb_rsp_err(s_rsp_err),
    .s_icb_rsp_rdata(s_rsp_rdata),
    .arb_busy(arb_busy), .rsp_orphan(rsp_orphan)
  );

  task automatic idle_inputs();
    m0_cmd_valid = 0; m0_cmd_addr = '0; m0_cmd_read = 0; m0_cmd_wdata = '0; m0_cmd_wmask = '0;
    m1_cmd_valid = 0; m1_cmd_addr = '0; m1_cmd_read = 0; m1_cmd_wdata = '0; m1_cmd_wmask = '0;
    m0_rsp_ready = 0; m1_rsp_ready = 0;
    s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_err = 0; s_rsp_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if ({s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready, arb_busy, rsp_orphan} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b want 00000000",
        {s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready, arb_busy, rsp_orphan}); end
  endtask

  task automatic test_single_read();
    apply_reset();
    @(negedge clk);
    m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 32'h8000_0000; s_cmd_ready = 1;
    #1;
    checks++; if (s_cmd_valid !== 1'b1) begin errors++; $display("FAIL t1_s_cmd_valid got %b want 1", s_cmd_valid); end
    checks++; if (m0_cmd_ready !== 1'b1) begin errors++; $display("FAIL t1_m0_cmd_ready got %b want 1", m0_cmd_ready); end
    checks++; if (s_cmd_addr !== 32'h8000_0000) begin errors++; $display("FAIL t1_addr got %h want 80000000", s_cmd_addr); end
    checks++; if (s_cmd_read !== 1'b1) begin errors++; $display("FAIL t1_read got %b want 1", s_cmd_read); end
    @(negedge clk);
    m0_cmd_valid = 0; s_rsp_valid = 1; s_rsp_rdata = 32'h1234; m0_rsp_ready = 1; m1_rsp_ready = 1;
    #1;
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b want 1", arb_busy); end
    checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b10) begin errors++; $display("FAIL t1_rsp_route got %b want 10", {m0_rsp_valid, m1_rsp_valid}); end
    checks++; if (m0_rsp_rdata !== 32'h1234) begin errors++; $display("FAIL t1_rdata got %h want 00001234", m0_rsp_rdata); end
    checks++; if (s_rsp_ready !== 1'b1) begin errors++; $display("FAIL t1_s_rsp_ready got %b want 1", s_rsp_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy got %b want 0", arb_busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant;
    logic [4:0] exp_head;
    exp_grant = 4'b1010;  // bit i = granted master in cycle i: m0,m1,m0,m1
    exp_head  = 5'b10100; // bit i = head master responding in cycle i (from cycle 1)
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m0_cmd_valid = (i < 4); m0_cmd_addr = 32'h100 + 32'(i);
      m1_cmd_valid = (i < 4); m1_cmd_addr = 32'h200 + 32'(i);
      s_cmd_ready = 1; s_rsp_valid = (i > 0); s_rsp_rdata = 32'hA0 + 32'(i);
      m0_rsp_ready = 1; m1_rsp_ready = 1;
      #1;
      if (i < 4) begin
        checks++; if ({m1_cmd_ready, m0_cmd_ready} !== (exp_grant[i] ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL t2_grant[%0d] got %b want m%0d", i, {m1_cmd_ready, m0_cmd_ready}, exp_grant[i]); end
        checks++; if (s_cmd_addr !== (exp_grant[i] ? 32'h200 : 32'h100) + 32'(i)) begin
          errors++; $display("FAIL t2_addr[%0d] got %h", i, s_cmd_addr); end
      end
      if (i > 0) begin
        checks++; if ({m1_rsp_valid, m0_rsp_valid} !== (exp_head[i] ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL t2_rsp[%0d] got %b want m%0d", i, {m1_rsp_valid, m0_rsp_valid}, exp_head[i]); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL t2_drain got %b want 0", arb_busy); end
  endtask

  task automatic test_lock();
    apply_reset();
    // one m0 transaction first so the round-robin pointer favours m1
    @(negedge clk); m0_cmd_valid = 1; m0_cmd_addr = 32'h10; s_cmd_ready = 1;
    @(negedge clk); m0_cmd_valid = 0; s_rsp_valid = 1; m0_rsp_ready = 1;
    @(negedge clk); s_rsp_valid = 0;
    m0_cmd_valid = 1; m0_cmd_addr = 32'hA0; s_cmd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      m1_cmd_valid = (i > 0); m1_cmd_addr = 32'hB0;
      #1;
      checks++; if (s_cmd_addr !== 32'hA0) begin errors++; $display("FAIL t3_stall_addr[%0d] got %h want 000000a0", i, s_cmd_addr); end
      checks++; if (s_cmd_valid !== 1'b1) begin errors++; $display("FAIL t3_stall_valid[%0d] got %b want 1", i, s_cmd_valid); end
    end
    @(negedge clk); s_cmd_ready = 1;
    #1;
    checks++; if ({m1_cmd_ready, m0_cmd_ready} !== 2'b01) begin errors++; $display("FAIL t3_hsk got %b want 01", {m1_cmd_ready, m0_cmd_ready}); end
    checks++; if (s_cmd_addr !== 32'hA0) begin errors++; $display("FAIL t3_hsk_addr got %h want 000000a0", s_cmd_addr); end
    @(negedge clk); m0_cmd_valid = 0;
    #1;
    checks++; if ({m1_cmd_ready, m0_cmd_ready} !== 2'b10) begin errors++; $display("FAIL t3_m1_grant got %b want 10", {m1_cmd_ready, m0_cmd_ready}); end
    checks++; if (s_cmd_addr !== 32'hB0) begin errors++; $display("FAIL t3_m1_addr got %h want 000000b0", s_cmd_addr); end
  endtask

  task automatic test_full();
    apply_reset();
    @(negedge clk); m0_cmd_valid = 1; s_cmd_ready = 1; m0_rsp_ready = 1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (s_cmd_valid !== 1'b1) begin errors++; $display("FAIL t4_issue[%0d] got %b want 1", i, s_cmd_valid); end
    end
    @(negedge clk); s_rsp_valid = 1;
    #1;
    checks++; if ({s_cmd_valid, m0_cmd_ready} !== 2'b00) begin errors++; $display("FAIL t4_full_block got %b want 00", {s_cmd_valid, m0_cmd_ready}); end
    checks++; if (s_rsp_ready !== 1'b1) begin errors++; $display("FAIL t4_pop got %b want 1", s_rsp_ready); end
    @(negedge clk); s_rsp_valid = 0;
    #1;
    checks++; if ({s_cmd_valid, m0_cmd_ready} !== 2'b11) begin errors++; $display("FAIL t4_reissue got %b want 11", {s_cmd_valid, m0_cmd_ready}); end
    @(negedge clk);
    #1;
    checks++; if (s_cmd_valid !== 1'b0) begin errors++; $display("FAIL t4_full_again got %b want 0", s_cmd_valid); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL t4_busy got %b want 1", arb_busy); end
  endtask

  task automatic test_rsp_block();
    apply_reset();
    @(negedge clk); m1_cmd_valid = 1; s_cmd_ready = 1;
    #1;
    checks++; if (m1_cmd_ready !== 1'b1) begin errors++; $display("FAIL t5_issue got %b want 1", m1_cmd_ready); end
    @(negedge clk);
    m1_cmd_valid = 0; s_rsp_valid = 1; s_rsp_err = 1; s_rsp_rdata = 32'h55; m1_rsp_ready = 0; m0_rsp_ready = 1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if ({s_rsp_ready, m0_rsp_valid, m1_rsp_valid} !== 3'b001) begin
        errors++; $display("FAIL t5_block[%0d] got %b want 001", i, {s_rsp_ready, m0_rsp_valid, m1_rsp_valid}); end
    end
    checks++; if ({m0_rsp_err, m1_rsp_err} !== 2'b11) begin errors++; $display("FAIL t5_err_bcast got %b want 11", {m0_rsp_err, m1_rsp_err}); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL t5_held got %b want 1", arb_busy); end
    @(negedge clk); m1_rsp_ready = 1;
    #1;
    checks++; if (s_rsp_ready !== 1'b1) begin errors++; $display("FAIL t5_release got %b want 1", s_rsp_ready); end
    @(negedge clk); idle_inputs();
    #1;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL t5_popped got %b want 0", arb_busy); end
  endtask

  task automatic test_orphan_reset();
    apply_reset();
    @(negedge clk); s_rsp_valid = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
    #1;
    checks++; if ({s_rsp_ready, m0_rsp_valid, m1_rsp_valid, rsp_orphan} !== 4'b0000) begin
      errors++; $display("FAIL t6_empty_rsp got %b want 0000", {s_rsp_ready, m0_rsp_valid, m1_rsp_valid, rsp_orphan}); end
    @(negedge clk); s_rsp_valid = 0;
    #1;
    checks++; if (rsp_orphan !== 1'b1) begin errors++; $display("FAIL t6_orphan_set got %b want 1", rsp_orphan); end
    @(negedge clk); m0_cmd_valid = 1; s_cmd_ready = 1;
    @(negedge clk); m1_cmd_valid = 1;
    #1;
    checks++; if (rsp_orphan !== 1'b1) begin errors++; $display("FAIL t6_orphan_sticky got %b want 1", rsp_orphan); end
    checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL t6_busy got %b want 1", arb_busy); end
    #1 rst_n = 0;
    #1;
    checks++; if ({arb_busy, rsp_orphan} !== 2'b00) begin errors++; $display("FAIL t6_async_rst got %b want 00", {arb_busy, rsp_orphan}); end
    idle_inputs();
    #1;
    checks++; if ({s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 6'b000000) begin
      errors++; $display("FAIL t6_rst_outputs got %b want 000000",
        {s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready}); end
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_full();
    test_rsp_block();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
